// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state encoding, port ids and default geometry
// for the SRAM arbiter and its round-robin sub-block.
package sram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DEF_AW = 4;
    localparam int DEF_DW = 8;

    function automatic logic other_port(input logic p);
        return p == PORT_A ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; the port just served loses priority.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio;

    assign gnt[0] = en & req[0] & (~req[1] | (prio == PORT_A));
    assign gnt[1] = en & req[1] & (~req[0] | (prio == PORT_B));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio <= PORT_A;
        else if (|gnt)
            prio <= other_port(gnt[1] ? PORT_B : PORT_A);
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of a single-port SRAM between ports A and B,
// clearing the array to zero after reset before any access is granted.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          A_REQ,
    input  logic          A_WE,
    input  logic [AW-1:0] A_ADDR,
    input  logic [DW-1:0] A_WDATA,
    output logic          A_GNT,
    output logic          A_RVALID,
    output logic [DW-1:0] A_RDATA,
    input  logic          B_REQ,
    input  logic          B_WE,
    input  logic [AW-1:0] B_ADDR,
    input  logic [DW-1:0] B_WDATA,
    output logic          B_GNT,
    output logic          B_RVALID,
    output logic [DW-1:0] B_RDATA,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    output logic          MEM_WREN,
    input  logic [DW-1:0] MEM_RDATA,
    output logic          INIT_DONE
);

    state_t        state;
    logic [AW-1:0] cnt;
    logic [1:0]    gnt;
    logic          g_any, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic          t1_v, t1_p, t2_v, t2_p;

    rr_arb2 u_arb (
        .clk   (CLK),
        .rst_n (RST),
        .en    (state == ST_RUN),
        .req   ({B_REQ, A_REQ}),
        .gnt   (gnt)
    );

    assign A_GNT = gnt[0];
    assign B_GNT = gnt[1];

    always_comb begin
        g_any   = |gnt;
        g_we    = gnt[1] ? B_WE    : A_WE;
        g_addr  = gnt[1] ? B_ADDR  : A_ADDR;
        g_wdata = gnt[1] ? B_WDATA : A_WDATA;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_INIT;
            cnt       <= '0;
            MEM_WREN  <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            INIT_DONE <= 1'b0;
            A_RVALID  <= 1'b0;
            B_RVALID  <= 1'b0;
            A_RDATA   <= '0;
            B_RDATA   <= '0;
            t1_v      <= 1'b0;
            t1_p      <= PORT_A;
            t2_v      <= 1'b0;
            t2_p      <= PORT_A;
        end else begin
            // tag pipe: t1 = SRAM sampling cycle, t2 = data on MEM_RDATA
            t1_v     <= g_any & ~g_we;
            t1_p     <= gnt[1] ? PORT_B : PORT_A;
            t2_v     <= t1_v;
            t2_p     <= t1_p;
            A_RVALID <= t2_v & (t2_p == PORT_A);
            B_RVALID <= t2_v & (t2_p == PORT_B);
            if (t2_v && t2_p == PORT_A)
                A_RDATA <= MEM_RDATA;
            if (t2_v && t2_p == PORT_B)
                B_RDATA <= MEM_RDATA;
            if (state == ST_INIT) begin
                MEM_WREN  <= 1'b1;
                MEM_ADDR  <= cnt;
                MEM_WDATA <= '0;
                cnt       <= cnt + 1'b1;
                if (&cnt) begin
                    state     <= ST_RUN;
                    INIT_DONE <= 1'b1;
                end
            end else begin
                MEM_WREN <= g_any & g_we;
                if (g_any) begin
                    MEM_ADDR  <= g_addr;
                    MEM_WDATA <= g_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and random traffic against a grant-order memory model.
module tb_sram_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       A_REQ = 1'b0, A_WE = 1'b0, B_REQ = 1'b0, B_WE = 1'b0;
    logic [3:0] A_ADDR = '0, B_ADDR = '0;
    logic [7:0] A_WDATA = '0, B_WDATA = '0;
    logic       A_GNT, A_RVALID, B_GNT, B_RVALID, MEM_WREN, INIT_DONE;
    logic [7:0] A_RDATA, B_RDATA, MEM_WDATA;
    logic [7:0] MEM_RDATA;
    logic [3:0] MEM_ADDR;

    sram_arbiter #(.AW(4), .DW(8)) dut (
        .CLK(CLK), .RST(RST),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
        .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
        .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WREN(MEM_WREN),
        .MEM_RDATA(MEM_RDATA), .INIT_DONE(INIT_DONE)
    );

    always #5 CLK = ~CLK;

    // cycle-accurate single-port SRAM: samples in n+1, data out in n+2
    logic [7:0] sram [16];
    always @(posedge CLK) begin
        if (MEM_WREN)
            sram[MEM_ADDR] <= MEM_WDATA;
        MEM_RDATA <= sram[MEM_ADDR];
    end

    typedef struct {
        logic       p;
        logic [7:0] d;
        int         due;
    } ret_t;

    ret_t       q[$];
    logic [7:0] mm [16];
    logic [7:0] last_a, last_b;
    logic       prio, pw;
    bit         a_keep, b_keep;
    int         checks, errors, cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_a(input logic we, input logic [3:0] addr, input logic [7:0] d);
        A_REQ = 1'b1; A_WE = we; A_ADDR = addr; A_WDATA = d;
    endtask

    task automatic set_b(input logic we, input logic [3:0] addr, input logic [7:0] d);
        B_REQ = 1'b1; B_WE = we; B_ADDR = addr; B_WDATA = d;
    endtask

    task automatic tick;
        logic       ga, gb, ev_a, ev_b, run, we;
        logic [3:0] addr;
        logic [7:0] wd;
        @(negedge CLK);
        run = cyc >= 16;
        ga = run && A_REQ && (!B_REQ || prio == 1'b0);
        gb = run && B_REQ && (!A_REQ || prio == 1'b1);
        chk("a_gnt", A_GNT, ga);
        chk("b_gnt", B_GNT, gb);
        chk("init_done", INIT_DONE, run);
        if (cyc >= 1 && cyc <= 16) begin
            chk("init_wren", MEM_WREN, 1);
            chk("init_addr", MEM_ADDR, cyc - 1);
            chk("init_wdata", MEM_WDATA, 0);
        end else
            chk("mem_wren", MEM_WREN, pw);
        ev_a = 1'b0;
        ev_b = 1'b0;
        if (q.size() > 0) begin
            if (q[0].due == cyc) begin
                ev_a = (q[0].p == 1'b0);
                ev_b = (q[0].p == 1'b1);
                if (ev_a) last_a = q[0].d;
                if (ev_b) last_b = q[0].d;
                void'(q.pop_front());
            end
        end
        chk("a_rvalid", A_RVALID, ev_a);
        chk("b_rvalid", B_RVALID, ev_b);
        chk("a_rdata", A_RDATA, last_a);
        chk("b_rdata", B_RDATA, last_b);
        pw = 1'b0;
        if (ga || gb) begin
            addr = ga ? A_ADDR : B_ADDR;
            we   = ga ? A_WE : B_WE;
            wd   = ga ? A_WDATA : B_WDATA;
            if (we)
                mm[addr] = wd;
            else
                q.push_back('{gb, mm[addr], cyc + 3});
            pw   = we;
            prio = ga;
        end
        @(posedge CLK);
        cyc++;
        #1;
        if (ga && !a_keep) A_REQ = 1'b0;
        if (gb && !b_keep) B_REQ = 1'b0;
    endtask

    task automatic do_reset;
        #1 RST = 1'b0;
        #1;
        chk("rst_a_rvalid", A_RVALID, 0);
        chk("rst_b_rvalid", B_RVALID, 0);
        chk("rst_a_rdata", A_RDATA, 0);
        chk("rst_b_rdata", B_RDATA, 0);
        chk("rst_wren", MEM_WREN, 0);
        chk("rst_addr", MEM_ADDR, 0);
        chk("rst_init_done", INIT_DONE, 0);
        @(posedge CLK);
        #1 RST = 1'b1;
        cyc = 0;
        q.delete();
        prio = 1'b0;
        pw = 1'b0;
        last_a = '0;
        last_b = '0;
        foreach (mm[i]) mm[i] = '0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while ((A_REQ || B_REQ) && n < 60) begin
            tick;
            n++;
        end
        chk("idle_timeout", A_REQ || B_REQ, 0);
        repeat (4) tick;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        a_keep = 0;
        b_keep = 0;
        do_reset;
        // request raised during INIT must wait for the first RUN cycle
        set_a(1'b0, 4'd5, 8'h00);
        repeat (16) tick;
        wait_idle;
        chk("init_read", A_RDATA, 8'h00);
        set_a(1'b1, 4'd1, 8'hAA);
        wait_idle;
        set_a(1'b0, 4'd1, 8'h00);
        wait_idle;
        chk("read_aa", A_RDATA, 8'hAA);
        set_a(1'b1, 4'd2, 8'h11);
        wait_idle;
        set_b(1'b1, 4'd3, 8'h22);
        wait_idle;
        a_keep = 1;
        b_keep = 1;
        set_a(1'b0, 4'd2, 8'h00);
        set_b(1'b0, 4'd3, 8'h00);
        repeat (4) tick;
        a_keep = 0;
        b_keep = 0;
        A_REQ = 1'b0;
        B_REQ = 1'b0;
        repeat (4) tick;
        chk("alt_a", A_RDATA, 8'h11);
        chk("alt_b", B_RDATA, 8'h22);
        set_b(1'b1, 4'd7, 8'h5C);
        wait_idle;
        set_a(1'b0, 4'd7, 8'h00);
        wait_idle;
        chk("read_5c", A_RDATA, 8'h5C);
        // two reads in flight, then reset before either returns
        set_a(1'b0, 4'd2, 8'h00);
        set_b(1'b0, 4'd3, 8'h00);
        tick;
        tick;
        do_reset;
        repeat (16) tick;
        set_a(1'b0, 4'd2, 8'h00);
        wait_idle;
        chk("post_rst_read", A_RDATA, 8'h00);
        b_keep = 1;
        set_b(1'b0, 4'd9, 8'h00);
        repeat (8) tick;
        b_keep = 0;
        B_REQ = 1'b0;
        repeat (4) tick;
        repeat (400) begin
            tick;
            if (!A_REQ && $urandom_range(1) == 1)
                set_a(1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom_range(255)));
            if (!B_REQ && $urandom_range(1) == 1)
                set_b(1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom_range(255)));
        end
        wait_idle;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
